ctrl_decode_pipe: RTL and testbench

CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

---
 rtl/ctrl_decode_pipe.sv | 197 +++++++++++++++++++
 tb/tb_ctrl_decode_pipe.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: single-entry decode stage between IF and EX.
// Decodes the RV32 opcode into registered control bits and register fields.
// It inserts a bubble on a load-use hazard and counts stall cycles.
// Optional feature macro: CTRL_AMO_EN (decode opcode 0101111 as AMO).
module ctrl_decode_pipe #(
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [PC_W-1:0]       in_pc,
    input  logic                  flush,
    input  logic                  cnt_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_jal,
    output logic                  out_jalr,
    output logic                  out_branch,
    output logic                  out_mem_read,
    output logic                  out_mem_to_reg,
    output logic                  out_mem_write,
    output logic                  out_alu_src,
    output logic                  out_reg_write,
    output logic                  out_illegal,
    output logic [1:0]            out_alu_op,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic [REG_ADDR_W-1:0] out_rs1,
    output logic [REG_ADDR_W-1:0] out_rs2,
    output logic [PC_W-1:0]       out_pc,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef CTRL_AMO_EN
    localparam logic [6:0] OP_AMO    = 7'b0101111;
`endif

    logic [6:0] opcode_s;
    logic       raw_jal_s, raw_jalr_s, raw_branch_s, raw_mem_read_s, raw_mem_to_reg_s;
    logic       raw_mem_write_s, raw_alu_src_s, raw_reg_write_s;
    logic [1:0] raw_alu_op_s;
    logic       raw_rs1_used_s, raw_rs2_used_s, opc_bad_s, field_bad_s, illegal_s;
    logic       rs1_used_s, rs2_used_s;
    logic [REG_ADDR_W-1:0] rd_s, rs1_s, rs2_s, rd_idx_s, rs1_idx_s, rs2_idx_s;
    logic       advance_s, hazard_s, xfer_s, stall_inc_s;
    logic       unused_bits_s;

    assign opcode_s      = in_instr[6:0];
    assign rd_idx_s      = in_instr[7 +: REG_ADDR_W];
    assign rs1_idx_s     = in_instr[15 +: REG_ADDR_W];
    assign rs2_idx_s     = in_instr[20 +: REG_ADDR_W];
    assign unused_bits_s = ^{in_instr[31:25], in_instr[14:12]};

    // Opcode decode into raw control bits and register-use flags
    always_comb begin
        raw_jal_s        = 1'b0;
        raw_jalr_s       = 1'b0;
        raw_branch_s     = 1'b0;
        raw_mem_read_s   = 1'b0;
        raw_mem_to_reg_s = 1'b0;
        raw_mem_write_s  = 1'b0;
        raw_alu_src_s    = 1'b0;
        raw_reg_write_s  = 1'b0;
        raw_alu_op_s     = 2'b00;
        raw_rs1_used_s   = 1'b0;
        raw_rs2_used_s   = 1'b0;
        opc_bad_s        = 1'b0;
        case (opcode_s)
            OP_LOAD: begin
                raw_mem_read_s = 1'b1; raw_mem_to_reg_s = 1'b1; raw_reg_write_s = 1'b1;
                raw_alu_src_s  = 1'b1; raw_rs1_used_s = 1'b1;
            end
            OP_STORE: begin
                raw_mem_write_s = 1'b1; raw_alu_src_s = 1'b1;
                raw_rs1_used_s  = 1'b1; raw_rs2_used_s = 1'b1;
            end
            OP_BRANCH: begin
                raw_branch_s   = 1'b1; raw_alu_op_s = 2'b01;
                raw_rs1_used_s = 1'b1; raw_rs2_used_s = 1'b1;
            end
            OP_R: begin
                raw_reg_write_s = 1'b1; raw_alu_op_s = 2'b10;
                raw_rs1_used_s  = 1'b1; raw_rs2_used_s = 1'b1;
            end
            OP_IALU: begin
                raw_reg_write_s = 1'b1; raw_alu_src_s = 1'b1; raw_alu_op_s = 2'b10;
                raw_rs1_used_s  = 1'b1;
            end
            OP_JAL: begin
                raw_jal_s = 1'b1; raw_reg_write_s = 1'b1; raw_alu_src_s = 1'b1;
                raw_alu_op_s = 2'b10;
            end
            OP_JALR: begin
                raw_jalr_s = 1'b1; raw_reg_write_s = 1'b1; raw_alu_src_s = 1'b1;
                raw_alu_op_s = 2'b10; raw_rs1_used_s = 1'b1;
            end
            OP_LUI: begin
                raw_reg_write_s = 1'b1; raw_alu_src_s = 1'b1; raw_alu_op_s = 2'b11;
            end
            OP_AUIPC: begin
                raw_reg_write_s = 1'b1; raw_alu_src_s = 1'b1; raw_alu_op_s = 2'b00;
            end
`ifdef CTRL_AMO_EN
            OP_AMO: begin
                raw_reg_write_s = 1'b1; raw_mem_read_s = 1'b1; raw_mem_write_s = 1'b1;
                raw_mem_to_reg_s = 1'b1; raw_rs1_used_s = 1'b1; raw_rs2_used_s = 1'b1;
            end
`endif
            default: opc_bad_s = 1'b1;
        endcase
    end

    // RV32E build: a used register field naming x16..x31 is illegal
    always_comb begin
        if (REG_ADDR_W < 5) begin
            field_bad_s = (raw_reg_write_s & in_instr[11]) |
                          (raw_rs1_used_s  & in_instr[19]) |
                          (raw_rs2_used_s  & in_instr[24]);
        end else begin
            field_bad_s = 1'b0;
        end
    end

    assign illegal_s  = opc_bad_s | field_bad_s;
    assign rs1_used_s = raw_rs1_used_s & ~illegal_s;
    assign rs2_used_s = raw_rs2_used_s & ~illegal_s;
    assign rd_s       = (raw_reg_write_s & ~illegal_s) ? rd_idx_s  : '0;
    assign rs1_s      = rs1_used_s                     ? rs1_idx_s : '0;
    assign rs2_s      = rs2_used_s                     ? rs2_idx_s : '0;

    assign advance_s   = ~out_valid | out_ready;
    assign hazard_s    = out_valid & out_mem_read & (out_rd != '0) &
                         ((rs1_used_s & (rs1_idx_s == out_rd)) |
                          (rs2_used_s & (rs2_idx_s == out_rd)));
    assign in_ready    = rst_n & advance_s & ~hazard_s & ~flush;
    assign xfer_s      = in_valid & in_ready;
    assign stall_inc_s = in_valid & advance_s & hazard_s & ~flush;

    // Decode pipeline register: flush clears, advance loads or bubbles, else hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0; out_jal <= 1'b0; out_jalr <= 1'b0; out_branch <= 1'b0;
            out_mem_read <= 1'b0; out_mem_to_reg <= 1'b0; out_mem_write <= 1'b0;
            out_alu_src <= 1'b0; out_reg_write <= 1'b0; out_illegal <= 1'b0;
            out_alu_op <= 2'b00; out_rd <= '0; out_rs1 <= '0; out_rs2 <= '0; out_pc <= '0;
        end else if (flush || (advance_s && !xfer_s)) begin
            out_valid <= 1'b0; out_jal <= 1'b0; out_jalr <= 1'b0; out_branch <= 1'b0;
            out_mem_read <= 1'b0; out_mem_to_reg <= 1'b0; out_mem_write <= 1'b0;
            out_alu_src <= 1'b0; out_reg_write <= 1'b0; out_illegal <= 1'b0;
            out_alu_op <= 2'b00;
        end else if (advance_s) begin
            out_valid      <= 1'b1;
            out_jal        <= raw_jal_s        & ~illegal_s;
            out_jalr       <= raw_jalr_s       & ~illegal_s;
            out_branch     <= raw_branch_s     & ~illegal_s;
            out_mem_read   <= raw_mem_read_s   & ~illegal_s;
            out_mem_to_reg <= raw_mem_to_reg_s & ~illegal_s;
            out_mem_write  <= raw_mem_write_s  & ~illegal_s;
            out_alu_src    <= raw_alu_src_s    & ~illegal_s;
            out_reg_write  <= raw_reg_write_s  & ~illegal_s;
            out_illegal    <= illegal_s;
            out_alu_op     <= illegal_s ? 2'b00 : raw_alu_op_s;
            out_rd         <= rd_s;
            out_rs1        <= rs1_s;
            out_rs2        <= rs2_s;
            out_pc         <= in_pc;
        end else begin
            out_valid <= out_valid;
        end
    end

    // Load-use stall counter: clear wins, otherwise saturating increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cnt_clr) begin
            stall_cnt <= '0;
        end else if (stall_inc_s && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end else begin
            stall_cnt <= stall_cnt;
        end
    end

endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// Scoreboard bench for ctrl_decode_pipe: randomized instruction stream with
// directed opening scenarios, checked against a behavioural model.
module tb_ctrl_decode_pipe;

    localparam int CNT_W = 2;
    localparam int NCYC  = 2500;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, flush, cnt_clr, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc;
    logic        out_jal, out_jalr, out_branch, out_mem_read, out_mem_to_reg;
    logic        out_mem_write, out_alu_src, out_reg_write, out_illegal;
    logic [1:0]  out_alu_op;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [CNT_W-1:0] stall_cnt;

    ctrl_decode_pipe #(.PC_W(32), .REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .cnt_clr(cnt_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_jal(out_jal),
        .out_jalr(out_jalr), .out_branch(out_branch), .out_mem_read(out_mem_read),
        .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write),
        .out_alu_src(out_alu_src), .out_reg_write(out_reg_write),
        .out_illegal(out_illegal), .out_alu_op(out_alu_op), .out_rd(out_rd),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_pc(out_pc), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic illegal, jal, jalr, branch, mr, mtr, mw, as, rw;
        logic [1:0] op;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] pc;
        logic u1, u2;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    // model state: what the output register should contain
    logic       m_v, m_mr, m_zero;
    logic [4:0] m_rd;
    logic [CNT_W-1:0] m_cnt;
    // inputs applied for the coming edge and their predicted consequences
    logic a_rst, a_iv, a_fl, a_ordy, a_clr, a_adv, a_haz, a_rdy, a_xfer;
    exp_t a_exp;

    // Expected decode from the opcode table and register-use rules
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        e = '0;
        case (ins[6:0])
            7'b0000011: begin e.mr = 1; e.mtr = 1; e.rw = 1; e.as = 1; e.u1 = 1; end
            7'b0100011: begin e.mw = 1; e.as = 1; e.u1 = 1; e.u2 = 1; end
            7'b1100011: begin e.branch = 1; e.op = 2'b01; e.u1 = 1; e.u2 = 1; end
            7'b0110011: begin e.rw = 1; e.op = 2'b10; e.u1 = 1; e.u2 = 1; end
            7'b0010011: begin e.rw = 1; e.as = 1; e.op = 2'b10; e.u1 = 1; end
            7'b1101111: begin e.jal = 1; e.rw = 1; e.as = 1; e.op = 2'b10; end
            7'b1100111: begin e.jalr = 1; e.rw = 1; e.as = 1; e.op = 2'b10; e.u1 = 1; end
            7'b0110111: begin e.rw = 1; e.as = 1; e.op = 2'b11; end
            7'b0010111: begin e.rw = 1; e.as = 1; e.op = 2'b00; end
`ifdef CTRL_AMO_EN
            7'b0101111: begin e.rw = 1; e.mr = 1; e.mw = 1; e.mtr = 1; e.u1 = 1; e.u2 = 1; end
`endif
            default:    e.illegal = 1;
        endcase
        e.rd  = e.rw ? ins[11:7]  : 5'd0;
        e.rs1 = e.u1 ? ins[19:15] : 5'd0;
        e.rs2 = e.u2 ? ins[24:20] : 5'd0;
        e.pc  = pc;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs that were applied
    task automatic model_step();
        if (a_fl) begin
            if (m_v && !a_ordy && sb.size() != 0) sb.delete(0);
            m_v = 1'b0; m_mr = 1'b0; m_zero = 1'b1;
        end else if (a_adv) begin
            if (a_xfer) begin
                m_v = 1'b1; m_mr = a_exp.mr; m_rd = a_exp.rd; m_zero = 1'b0;
            end else begin
                m_v = 1'b0; m_mr = 1'b0;
            end
        end
        if (a_clr) m_cnt = '0;
        else if (a_iv && a_adv && a_haz && !a_fl && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    endtask

    // Monitor: compare handshake, counter and consumed payloads each falling edge
    always @(negedge clk) begin
        exp_t e;
        chk("in_ready", 64'(in_ready), 64'(a_rdy));
        chk("out_valid", 64'(out_valid), 64'(m_v));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        if (!rst_n)
            chk("reset_fields", {out_jal, out_jalr, out_branch, out_mem_read, out_mem_to_reg,
                 out_mem_write, out_alu_src, out_reg_write, out_illegal, out_alu_op,
                 out_rd, out_rs1, out_rs2, out_pc}, 64'd0);
        else if (!out_valid && m_zero)
            chk("zero_ctrl", {out_jal, out_jalr, out_branch, out_mem_read, out_mem_to_reg,
                 out_mem_write, out_alu_src, out_reg_write, out_illegal, out_alu_op}, 64'd0);
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("payload",
                    {out_illegal, out_jal, out_jalr, out_branch, out_mem_read, out_mem_to_reg,
                     out_mem_write, out_alu_src, out_reg_write, out_alu_op,
                     out_rd, out_rs1, out_rs2, out_pc},
                    {e.illegal, e.jal, e.jalr, e.branch, e.mr, e.mtr, e.mw, e.as, e.rw,
                     e.op, e.rd, e.rs1, e.rs2, e.pc});
            end
        end
    end

    // Stimulus: reset, directed scenarios, then random traffic with a mid-run reset
    initial begin
        logic [6:0]  pool [13];
        logic [31:0] ins;
        int d;
        pool = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h13, 7'h6F, 7'h67, 7'h37, 7'h17,
                 7'h2F, 7'h00, 7'h7F, 7'h0B};
        m_v = 0; m_mr = 0; m_zero = 1; m_rd = 0; m_cnt = 0;
        a_rst = 0; a_iv = 0; a_fl = 0; a_ordy = 0; a_clr = 0;
        a_adv = 0; a_haz = 0; a_rdy = 0; a_xfer = 0; a_exp = '0;
        rst_n = 0; in_valid = 0; in_instr = 32'd0; in_pc = 32'd0;
        flush = 0; cnt_clr = 0; out_ready = 0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk); #1;
            if (a_rst) model_step();
            d = c - 3;
            in_valid = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
            in_pc = $urandom; in_instr = 32'h00500093;
            rst_n = !(c < 3 || (c >= 1200 && c < 1203));
            if (d >= 0 && d < 11) begin
                case (d)
                    0:       in_valid = 1'b1;
                    1:       begin in_valid = 1'b1; in_instr = 32'h0000A283; end
                    2, 3:    begin in_valid = 1'b1; in_instr = 32'h00128333; end
                    5:       in_valid = 1'b1;
                    6, 7, 8: begin in_valid = 1'b1; out_ready = 1'b0; end
                    9:       begin in_valid = 1'b1; out_ready = 1'b0; flush = 1'b1; end
                    10:      cnt_clr = 1'b1;
                    default: in_valid = 1'b0;
                endcase
            end else if (d >= 11) begin
                ins = $urandom;
                ins[6:0]   = pool[$urandom_range(0, 12)];
                ins[11:7]  = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                in_instr  = ins;
                in_valid  = ($urandom_range(0, 9) < 8);
                out_ready = ($urandom_range(0, 9) < 7);
                flush     = ($urandom_range(0, 29) == 0) && (c != 1203);
                cnt_clr   = ($urandom_range(0, 49) == 0);
            end
            a_iv = in_valid; a_fl = flush; a_ordy = out_ready; a_clr = cnt_clr;
            if (!rst_n) begin
                m_v = 0; m_mr = 0; m_zero = 1; m_rd = 0; m_cnt = 0;
                sb.delete();
                a_rst = 0; a_adv = 0; a_haz = 0; a_rdy = 0; a_xfer = 0;
            end else begin
                a_rst = 1;
                a_exp = model(in_instr, in_pc);
                a_adv = !m_v || out_ready;
                a_haz = m_v && m_mr && (m_rd != 5'd0) &&
                        ((a_exp.u1 && a_exp.rs1 == m_rd) || (a_exp.u2 && a_exp.rs2 == m_rd));
                a_rdy  = a_adv && !a_haz && !flush;
                a_xfer = in_valid && a_rdy;
                if (a_xfer) sb.push_back(a_exp);
            end
        end
        @(posedge clk); #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
